// File: rtl/t09_sound_pkg.sv
// Shared types and default tone/duration constants for the t09 buzzer sound generator.
package t09_sound_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int DUR_W_DEF     = 20;
  localparam int HALF_GOOD_DEF = 5682;
  localparam int HALF_MOVE_DEF = 11364;
  localparam int HALF_BAD1_DEF = 15152;
  localparam int HALF_BAD2_DEF = 22727;
  localparam int DUR_NOTE_DEF  = 1000000;
  localparam int DUR_MOVE_DEF  = 250000;

  // Numeric order is the retrigger priority.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    MOVE = 2'd1,
    GOOD = 2'd2,
    BAD  = 2'd3
  } snd_class_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NOTE_A = 2'd1,
    NOTE_B = 2'd2
  } snd_state_t;

  function automatic snd_class_t classify(input logic good, input logic bad, input logic move);
    snd_class_t c;
    if (bad) begin
      c = BAD;
    end else if (good) begin
      c = GOOD;
    end else if (move) begin
      c = MOVE;
    end else begin
      c = NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/t09_tone_div.sv
// Half-period square-wave divider; clr starts a fresh high phase, en=0 parks the output low.
module t09_tone_div
  import t09_sound_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] half,
  output logic             tone
);

  logic [CNT_W-1:0] cnt_r;

  // Tone toggles after `half` cycles in each phase.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tone  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      tone  <= 1'b1;
      cnt_r <= {CNT_W{1'b0}};
    end else if (!en) begin
      tone  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == half - CNT_W'(1)) begin
      tone  <= ~tone;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      tone  <= tone;
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/t09_sound_gen.sv
// Buzzer sound generator: turns playSound plus the causing game event into a timed
// square-wave burst (BAD = two descending notes, GOOD = one high note, MOVE = short click).
module t09_sound_gen
  import t09_sound_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int HALF_GOOD = HALF_GOOD_DEF,
  parameter int HALF_MOVE = HALF_MOVE_DEF,
  parameter int HALF_BAD1 = HALF_BAD1_DEF,
  parameter int HALF_BAD2 = HALF_BAD2_DEF,
  parameter int DUR_NOTE  = DUR_NOTE_DEF,
  parameter int DUR_MOVE  = DUR_MOVE_DEF
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       playSound,
  input  logic       mode_i,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic [3:0] direction,
  output logic       tone,
  output logic       busy
);

  localparam logic [CNT_W-1:0] H_GOOD = CNT_W'(HALF_GOOD);
  localparam logic [CNT_W-1:0] H_MOVE = CNT_W'(HALF_MOVE);
  localparam logic [CNT_W-1:0] H_BAD1 = CNT_W'(HALF_BAD1);
  localparam logic [CNT_W-1:0] H_BAD2 = CNT_W'(HALF_BAD2);
  localparam logic [DUR_W-1:0] D_NOTE = DUR_W'(DUR_NOTE);
  localparam logic [DUR_W-1:0] D_MOVE = DUR_W'(DUR_MOVE);

  function automatic logic [CNT_W-1:0] first_half(input snd_class_t c);
    logic [CNT_W-1:0] h;
    case (c)
      BAD:     h = H_BAD1;
      GOOD:    h = H_GOOD;
      MOVE:    h = H_MOVE;
      default: h = H_MOVE;
    endcase
    return h;
  endfunction

  function automatic logic [DUR_W-1:0] note_dur(input snd_class_t c);
    return (c == MOVE) ? D_MOVE : D_NOTE;
  endfunction

  snd_class_t       evt_q;
  snd_class_t       cls_r;
  snd_state_t       state_r;
  logic [CNT_W-1:0] half_r;
  logic [DUR_W-1:0] dur_r;
  logic [DUR_W-1:0] dur_cnt_r;

  snd_state_t       nxt_state_s;
  snd_class_t       nxt_cls_s;
  logic [CNT_W-1:0] nxt_half_s;
  logic [DUR_W-1:0] nxt_dur_s;
  logic             start_s;
  logic             trig_s;
  logic             expire_s;

  assign trig_s   = playSound & mode_i & (evt_q != NONE);
  assign expire_s = (dur_cnt_r == dur_r - DUR_W'(1));

  // Next-state decode; start_s marks any edge that enters a note with fresh counters.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cls_s   = cls_r;
    nxt_half_s  = half_r;
    nxt_dur_s   = dur_r;
    start_s     = 1'b0;
    if (!mode_i) begin
      nxt_state_s = IDLE;
      nxt_cls_s   = NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_s) begin
            nxt_state_s = NOTE_A;
            nxt_cls_s   = evt_q;
            nxt_half_s  = first_half(evt_q);
            nxt_dur_s   = note_dur(evt_q);
            start_s     = 1'b1;
          end else begin
            nxt_state_s = IDLE;
          end
        end
        NOTE_A: begin
          if (expire_s && (cls_r == BAD)) begin
            nxt_state_s = NOTE_B;
            nxt_half_s  = H_BAD2;
            nxt_dur_s   = D_NOTE;
            start_s     = 1'b1;
          end else if (trig_s && (expire_s || (evt_q > cls_r))) begin
            // an expiring note behaves like IDLE, so any trigger is taken
            nxt_state_s = NOTE_A;
            nxt_cls_s   = evt_q;
            nxt_half_s  = first_half(evt_q);
            nxt_dur_s   = note_dur(evt_q);
            start_s     = 1'b1;
          end else if (expire_s) begin
            nxt_state_s = IDLE;
            nxt_cls_s   = NONE;
          end else begin
            nxt_state_s = NOTE_A;
          end
        end
        NOTE_B: begin
          if (trig_s && (expire_s || (evt_q > cls_r))) begin
            nxt_state_s = NOTE_A;
            nxt_cls_s   = evt_q;
            nxt_half_s  = first_half(evt_q);
            nxt_dur_s   = note_dur(evt_q);
            start_s     = 1'b1;
          end else if (expire_s) begin
            nxt_state_s = IDLE;
            nxt_cls_s   = NONE;
          end else begin
            nxt_state_s = NOTE_B;
          end
        end
        default: begin
          nxt_state_s = IDLE;
          nxt_cls_s   = NONE;
        end
      endcase
    end
  end

  // State, latched note parameters, duration counter, busy and event alignment register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r   <= IDLE;
      cls_r     <= NONE;
      evt_q     <= NONE;
      half_r    <= {CNT_W{1'b0}};
      dur_r     <= {DUR_W{1'b0}};
      dur_cnt_r <= {DUR_W{1'b0}};
      busy      <= 1'b0;
    end else begin
      evt_q     <= classify(goodColl, badColl, |direction);
      state_r   <= nxt_state_s;
      cls_r     <= nxt_cls_s;
      half_r    <= nxt_half_s;
      dur_r     <= nxt_dur_s;
      busy      <= (nxt_state_s != IDLE);
      dur_cnt_r <= (start_s || (nxt_state_s == IDLE)) ? {DUR_W{1'b0}} : dur_cnt_r + DUR_W'(1);
    end
  end

  t09_tone_div #(
    .CNT_W (CNT_W)
  ) u_tone_div (
    .clk  (clk),
    .nRst (nRst),
    .clr  (start_s),
    .en   (nxt_state_s != IDLE),
    .half (half_r),
    .tone (tone)
  );

endmodule

// File: tb/tb_t09_sound_gen.sv
// Table-driven bench for t09_sound_gen using small HALF/DUR values.
module tb_t09_sound_gen;

  logic       clk = 1'b0;
  logic       nRst;
  logic       playSound;
  logic       mode_i;
  logic       goodColl;
  logic       badColl;
  logic [3:0] direction;
  logic       tone;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       good;
    logic       bad;
    logic [3:0] dir;
    logic       play;
    logic       mode;
    logic       exp_tone;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [0:255];
  int   nv = 0;

  t09_sound_gen #(
    .HALF_GOOD (2),
    .HALF_MOVE (3),
    .HALF_BAD1 (4),
    .HALF_BAD2 (5),
    .DUR_NOTE  (12),
    .DUR_MOVE  (6)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .playSound (playSound),
    .mode_i    (mode_i),
    .goodColl  (goodColl),
    .badColl   (badColl),
    .direction (direction),
    .tone      (tone),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic put(input logic g, input logic b, input logic [3:0] d, input logic p,
                     input logic m, input logic et, input logic eb);
    vec_t r;
    r.good = g; r.bad = b; r.dir = d; r.play = p; r.mode = m;
    r.exp_tone = et; r.exp_busy = eb;
    vecs[nv] = r;
    nv++;
  endtask

  // Expected tone of one note: high for the first `half` cycles of every 2*half.
  task automatic note_run(input int half, input int dur);
    for (int i = 0; i < dur; i++) begin
      put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, ((i / half) % 2) == 0, 1'b1);
    end
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: tone/busy=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic b, input logic [3:0] d, input logic p, input logic m);
    goodColl = g; badColl = b; direction = d; playSound = p; mode_i = m;
  endtask

  initial begin
    int idx;
    int j;
    int k;

    // 1: good note, with a stray playSound (no event) first
    put(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    put(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    idx = nv; note_run(2, 12); vecs[idx].play = 1'b1;
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2: bad pair, no gap between notes
    put(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    idx = nv; note_run(4, 12); note_run(5, 12); vecs[idx].play = 1'b1;
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3: move click with an equal-priority retrigger ignored
    put(1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
    idx = nv; note_run(3, 6); vecs[idx].play = 1'b1;
    vecs[idx+1].dir = 4'b0100; vecs[idx+2].play = 1'b1;
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 4: MOVE preempted by BAD; GOOD during both BAD notes ignored
    put(1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    idx = nv; note_run(3, 2);
    j = nv; note_run(4, 12); note_run(5, 12);
    vecs[idx].play = 1'b1; vecs[idx+1].bad = 1'b1; vecs[j].play = 1'b1;
    vecs[j+3].good = 1'b1; vecs[j+4].play = 1'b1;
    vecs[j+15].good = 1'b1; vecs[j+16].play = 1'b1;
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 4b: trigger on the expiry edge of a GOOD note starts MOVE with no gap
    put(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    idx = nv; note_run(2, 12);
    k = nv; note_run(3, 6);
    vecs[idx].play = 1'b1; vecs[k-1].dir = 4'b1000; vecs[k].play = 1'b1;
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: mute during NOTE_B, then a trigger while muted
    put(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    idx = nv; note_run(4, 12); note_run(5, 2); vecs[idx].play = 1'b1;
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    put(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    nRst = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    #12;
    chk("reset", {tone, busy}, 2'b00);
    @(negedge clk);
    nRst = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(vecs[i].good, vecs[i].bad, vecs[i].dir, vecs[i].play, vecs[i].mode);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {tone, busy}, {vecs[i].exp_tone, vecs[i].exp_busy});
    end

    // 6: asynchronous reset mid-note, then a normal replay
    @(negedge clk); drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("rst_pre", {tone, busy}, 2'b11);
    @(negedge clk); drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    @(posedge clk); #3;
    nRst = 1'b0;
    #1;
    chk("rst_async", {tone, busy}, 2'b00);
    @(negedge clk); nRst = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle", {tone, busy}, 2'b00);
    @(negedge clk); drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("replay0", {tone, busy}, 2'b11);
    @(negedge clk); drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("replay1", {tone, busy}, 2'b11);
    @(posedge clk); #1;
    chk("replay2", {tone, busy}, 2'b01);
    repeat (10) @(posedge clk);
    #1;
    chk("replay_end", {tone, busy}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
